// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared types for the instruction fetch unit: default address/instruction
// widths, the fetch state enum and the prefetch buffer entry layout.
package ifetch_pkg;

  localparam int AW_DEF = 8;   // program address width
  localparam int DW_DEF = 17;  // instruction width

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One prefetch buffer slot: the fetch address travels with its word so the
  // decoder always knows where the head instruction came from.
  typedef struct packed {
    logic [AW_DEF-1:0] pc;
    logic [DW_DEF-1:0] instr;
  } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Two-entry synchronous FIFO holding prefetched instruction entries.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   push, din    - write din at the tail (accepted when not full, or when a
//                  pop frees the head slot in the same cycle)
//   pop          - drop the head (ignored when empty)
//   flush        - empty the FIFO; overrides push and pop
//   full, count  - occupancy
//   head         - entry at the head (only meaningful when count != 0)
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter type T = entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  T           din,
  output logic       full,
  output logic [1:0] count,
  output T           head
);

  T           mem_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_pop, do_push, wr_en;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_pop   = pop && (count_q != 2'd0);
    // A full FIFO can still accept a push when the head leaves this cycle.
    do_push  = push && ((count_q != 2'd2) || do_pop);
    wr_en    = do_push && !flush;
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; it is only observed through count,
  // and the top zeroes its outputs whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  assign full  = (count_q == 2'd2);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Instruction fetch unit: owns the program counter, drives the program
// memory read port and streams fetched words to the decoder through a
// two-entry prefetch buffer with a valid/ready handshake.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   en                  - run enable; no new fetches while low
//   jmp_valid, jmp_addr - single-cycle redirect (flushes buffer in RUN)
//   addr, cs            - program memory read port (addr is the PC)
//   instr               - program memory data, combinational from addr/cs
//   instr_valid/_out/_pc, instr_ready - decoder handshake
// Optional feature macro IFETCH_PERF_EN adds:
//   perf_fetch_cnt      - 16-bit count of captures
//   perf_stall_cnt      - 16-bit count of RUN cycles with no fetch and no jump
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int            AW        = AW_DEF,
  parameter int            DW        = DW_DEF,
  parameter logic [AW-1:0] BOOT_ADDR = 8'h00,
  parameter logic [AW-1:0] END_ADDR  = 8'h21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          jmp_valid,
  input  logic [AW-1:0] jmp_addr,
  output logic [AW-1:0] addr,
  output logic          cs,
  input  logic [DW-1:0] instr,
  output logic          instr_valid,
  output logic [DW-1:0] instr_out,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]   perf_fetch_cnt,
  output logic [15:0]   perf_stall_cnt
`endif
);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } fetch_entry_t;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;

  logic          fifo_full;
  logic [1:0]    fifo_count;
  fetch_entry_t  fifo_head, fifo_din;
  logic          pop, flush, running;

  assign running     = (state_q == RUN);
  assign instr_valid = (fifo_count != 2'd0);
  assign pop         = instr_valid && instr_ready;
  // A jump in IDLE only retargets the PC; buffered words stay drainable.
  assign flush       = jmp_valid && running;
  assign cs          = running && !jmp_valid && (!fifo_full || pop);

  // Memory data is forced to zero when not selected so nothing stale is stored.
  assign fifo_din.pc    = pc_q;
  assign fifo_din.instr = instr & {DW{cs}};

  always_comb begin
    state_d = en ? RUN : IDLE;
    pc_d    = pc_q;
    if (jmp_valid) begin
      pc_d = jmp_addr;
    end else if (cs) begin
      pc_d = (pc_q == END_ADDR) ? BOOT_ADDR : pc_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= BOOT_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .T(fetch_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cs),
    .pop   (pop),
    .flush (flush),
    .din   (fifo_din),
    .full  (fifo_full),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign addr      = pc_q;
  assign instr_out = instr_valid ? fifo_head.instr : '0;
  assign instr_pc  = instr_valid ? fifo_head.pc    : '0;

`ifdef IFETCH_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (cs) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (running && !cs && !jmp_valid) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
// Randomized and directed stimulus for instr_fetch. A transaction-level model
// (PC plus a queue standing in for the prefetch buffer) predicts every
// delivered instruction; predictions go into a scoreboard queue that an
// independent monitor drains on each decoder handshake.
module tb_instr_fetch;

  localparam logic [7:0] BOOT = 8'h00;
  localparam logic [7:0] LAST = 8'h21;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, jmp_valid, instr_ready;
  logic [7:0]  jmp_addr;
  logic [7:0]  addr;
  logic        cs;
  logic [16:0] instr;
  logic        instr_valid;
  logic [16:0] instr_out;
  logic [7:0]  instr_pc;
`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  logic [16:0] rom [256];
  logic [16:0] junk;

  assign instr = cs ? rom[addr] : junk;

  instr_fetch #(
    .AW(8), .DW(17), .BOOT_ADDR(8'h00), .END_ADDR(8'h21)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .jmp_valid   (jmp_valid),
    .jmp_addr    (jmp_addr),
    .addr        (addr),
    .cs          (cs),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [16:0] ins;
  } item_t;

  item_t exp_q [$];  // scoreboard: deliveries the decoder should see
  item_t mq    [$];  // model of buffered instructions
  bit         m_run;
  logic [7:0] m_pc;
  int         m_fcnt, m_scnt;
  int         total = 0;
  int         bad   = 0;
  int         delivered = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [7:0] next_pc(input logic [7:0] pc);
    return (pc == LAST) ? BOOT : pc + 8'd1;
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_pc   = BOOT;
    m_fcnt = 0;
    m_scnt = 0;
    mq.delete();
  endtask

  // Runs one clock cycle; entered and left at posedge+1.
  task automatic cycle(input logic e, input logic j, input logic [7:0] ja, input logic r);
    bit m_valid, m_pop, m_fetch;
    if (j && !m_run) r = 1'b0;  // keep IDLE-jump pops out of the monitor's view
    en = e; jmp_valid = j; jmp_addr = ja; instr_ready = r;
    junk = 17'($urandom);
    m_valid = (mq.size() > 0);
    m_pop   = m_valid && r;
    m_fetch = m_run && !j && ((mq.size() < 2) || m_pop);
    if (m_pop && !j) exp_q.push_back(mq[0]);
    #2;
    check("cs", {31'd0, cs}, {31'd0, m_fetch});
    check("addr", {24'd0, addr}, {24'd0, m_pc});
    check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("head pc", {24'd0, instr_pc}, {24'd0, mq[0].pc});
      check("head instr", {15'd0, instr_out}, {15'd0, mq[0].ins});
    end
    @(posedge clk);
    #1;
    if (m_fetch) m_fcnt++;
    if (m_run && !m_fetch && !j) m_scnt++;
    if (j && m_run) begin
      mq.delete();
      m_pc = ja;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (j) begin
        m_pc = ja;
      end else if (m_fetch) begin
        mq.push_back('{pc: m_pc, ins: rom[m_pc]});
        m_pc = next_pc(m_pc);
      end
    end
    m_run = e;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cs"}, {31'd0, cs}, 32'd0);
    check({tag, " addr"}, {24'd0, addr}, {24'd0, BOOT});
    check({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, " instr_out"}, {15'd0, instr_out}, 32'd0);
    check({tag, " instr_pc"}, {24'd0, instr_pc}, 32'd0);
  endtask

  // Asserts rst between edges; entered and left at posedge+1.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compares every accepted handshake against the scoreboard head.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && instr_ready && !jmp_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected delivery: got pc %0h with no expected entry at %0t", instr_pc, $time);
        end else begin
          e = exp_q.pop_front();
          check("deliver pc", {24'd0, instr_pc}, {24'd0, e.pc});
          check("deliver instr", {15'd0, instr_out}, {15'd0, e.ins});
          delivered++;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 17'($urandom);
    rom[8'h01] = 17'b01000000000000100;
    rom[8'h10] = 17'b00000000001101000;
    junk = '0;
    en = 1'b0; jmp_valid = 1'b0; jmp_addr = '0; instr_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("power-on rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Free run through the end of the program and across the wrap to BOOT.
    for (int i = 0; i < 45; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Reset mid-run, then stall the decoder from startup and release it.
    async_reset();
    for (int i = 0; i < 8; i++)  cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("stall addr", {24'd0, addr}, 32'h02);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Fill the buffer, then redirect to 0x10 with the decoder ready.
    for (int i = 0; i < 3; i++)  cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h10, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("post-jump head pc", {24'd0, instr_pc}, 32'h10);
    check("post-jump head instr", {15'd0, instr_out}, {15'd0, 17'b00000000001101000});
    for (int i = 0; i < 4; i++)  cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Stop fetching with words buffered, jump while idle, drain, restart.
    for (int i = 0; i < 2; i++)  cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++)  cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'hFD, 1'b0);
    for (int i = 0; i < 4; i++)  cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++)  cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Random traffic, including jumps past END_ADDR that wrap modulo 256.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 8) != 0, ($urandom % 12) == 0, 8'($urandom), ($urandom % 3) != 0);
      if (i % 150 == 149) async_reset();
    end

`ifdef IFETCH_PERF_EN
    async_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++)  cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("perf fetch", {16'd0, perf_fetch_cnt}, 32'd10);
    check("perf stall", {16'd0, perf_stall_cnt}, 32'd3);
    for (int i = 0; i < 200; i++)
      cycle(($urandom % 8) != 0, ($urandom % 12) == 0, 8'($urandom), ($urandom % 3) != 0);
    check("perf fetch model", {16'd0, perf_fetch_cnt}, 32'(m_fcnt));
    check("perf stall model", {16'd0, perf_stall_cnt}, 32'(m_scnt));
`endif

    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that drives the program memory's `addr`/`cs` read port and hands fetched 17-bit instructions to the decoder. It keeps the program counter, captures each instruction word into a 2-entry prefetch buffer, and presents it downstream with a valid/ready handshake. It also handles sequential wrap-around and redirects (jumps) issued by the core.

## Interface

Parameters:
- `AW`, 8: program address width.
- `DW`, 17: instruction width.
- `BOOT_ADDR`, 8'h00: PC value after reset and after wrap.
- `END_ADDR`, 8'h21: last valid program address; the fetch after it goes to `BOOT_ADDR`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: run enable. While 0, no new fetches are issued.
- `jmp_valid` in 1: single-cycle redirect request.
- `jmp_addr` in AW: redirect target.
- `addr` out AW: program memory address. Equals the PC register.
- `cs` out 1: program memory select.
- `instr` in DW: program memory data. Combinational from `addr`/`cs`.
- `instr_valid` out 1: buffer head holds a valid instruction.
- `instr_out` out DW: head instruction.
- `instr_pc` out AW: address the head instruction was fetched from.
- `instr_ready` in 1: decoder accepts the head this cycle.

## Operation

- States:
  - IDLE: reset state. Moves to RUN when `en`=1.
  - RUN: moves to IDLE when `en`=0.
- Fetch condition: `cs` = RUN && !`jmp_valid` && (count<2 || pop). `cs` is combinational.
- Capture: on a clock edge with `cs`=1:
  - {`addr`, `instr`} is pushed into the buffer.
  - PC advances: `END_ADDR` goes to `BOOT_ADDR`; otherwise PC+1, modulo 2^AW.
- Pop: `instr_valid` && `instr_ready`. A pop and a push may occur in the same cycle when full, so sustained throughput is one instruction per cycle.
- Jump: when `jmp_valid`=1, the following happen at the clock edge:
  - the buffer is flushed (count=0);
  - PC is loaded with `jmp_addr`;
  - no capture occurs that cycle;
  - a simultaneous pop is discarded.
- A jump in IDLE only loads the PC.
- `en` deassertion: fetching stops after the current edge. Buffered entries are retained and remain drainable.
- When `cs`=0, the `instr` input is ignored. It reads as zero in that case.

## Timing

- Reset values (applied immediately on `rst` assertion, regardless of clock):
  - state=IDLE, PC=`BOOT_ADDR`, buffer count=0.
  - `addr`=`BOOT_ADDR`, `cs`=0.
  - `instr_valid`=0, `instr_out`=0, `instr_pc`=0.
- Startup: with `en` high at cycle 0, IDLE→RUN at edge 1. `cs`=1 during cycle 1. `instr_valid`=1 from cycle 2.
- Fetch-to-valid latency is 1 edge when the buffer is empty.
- Stall: with `instr_ready`=0, at most 2 words are captured, then `cs`=0. `addr` holds the next unfetched PC.
- Resume: when `instr_ready` returns to 1, fetching restarts in that same cycle. No word is lost or duplicated.
- Redirect: the first post-jump instruction is valid 2 edges after `jmp_valid`.
- Reset mid-operation aborts everything. In-flight buffer contents are discarded.

## Configuration

- `IFETCH_PERF_EN` defined:
  - Adds output `perf_fetch_cnt` (16 bits), which increments on every capture.
  - Adds output `perf_stall_cnt` (16 bits), which increments in RUN cycles where `cs`=0 and `jmp_valid`=0.
  - Both counters wrap at 16'hFFFF and reset to 0.
- `IFETCH_PERF_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Structure

- Package `ifetch_pkg`:
  - `AW`/`DW` defaults.
  - State enum {IDLE, RUN}.
  - Buffer entry struct {pc, instr}.
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO of entry structs.
  - Inputs: push, pop, flush.
  - Outputs: full, count, head.
  - Flush takes priority over push and pop.
- PC, state machine and perf counters live in `instr_fetch`.

## Test plan

- Reset, then `en`=1 and `instr_ready`=1:
  - `addr` sequence is 00, 01, 02, … at one per cycle.
  - The entry with `instr_pc`=01 has `instr_out`=17'b01000000000000100.
- Hold `instr_ready`=0 from startup:
  - Exactly 2 captures (pc 00, 01) occur, then `cs`=0 with `addr`=02.
  - After `instr_ready` rises, pcs 00, 01, 02, … are delivered in order, with no duplicate or loss.
- Free-run to the end of the program:
  - After the capture at `addr`=21, the next `addr`=00.
  - The pc sequence delivered is …20, 21, 00.
- With the buffer full, pulse `jmp_valid` with `jmp_addr`=10 while `instr_ready`=1:
  - Buffered entries are dropped.
  - The next `instr_valid` head has `instr_pc`=10 and `instr_out`=17'b00000000001101000.
- Assert `rst` asynchronously mid-run (between edges):
  - `cs`, `instr_valid`, `instr_out` and `instr_pc` go to 0, and `addr` goes to 00, before the next edge.
- With `IFETCH_PERF_EN`, 10 captures followed by 3 ready-stall cycles give `perf_fetch_cnt`=10 and `perf_stall_cnt`=3.
